rom_sample_streamer: RTL and testbench

- Streams signed audio samples from a synchronous sample ROM into the audio_codec write port, paced by write_ready instead of a divided clock.
- Adds the following over a free-running address counter:
  - one-shot or loop playback
  - programmable address step for pitch/speed
  - per-channel attenuation
  - start/stop control with status
- Sits between rom_lab5 (or any 1..N-cycle-latency ROM) and audio_codec in the top level.

---
 rtl/rom_sample_streamer.sv | 219 +++++++++++++++++++++
 tb/tb_rom_sample_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_sample_streamer.sv
// ---------------------------------------------------------------------------
// rom_sample_streamer
//
// Purpose:
//   Reads signed audio samples from a synchronous sample ROM and hands them
//   to the audio codec write port. Pacing comes from the codec's
//   write_ready, not from a divided clock. The block supports:
//     - one-shot or looped playback
//     - a programmable address step for pitch/speed
//     - per-channel attenuation (arithmetic right shift)
//     - start/stop control with busy/done status
//
// Ports:
//   clock           : system clock
//   reset           : synchronous, active-high; overrides everything
//   start           : level; begins playback from address 0 when idle
//   stop            : aborts playback; wins over start
//   loop_en         : 1 = wrap around at DEPTH, 0 = stop after last sample
//   step            : address increment per sample (0 behaves as 1)
//   atten_l/atten_r : per-channel arithmetic right shift (0..15)
//   rom_addr        : ROM address, driven straight from the address register
//   rom_q           : ROM data, valid ROM_LAT cycles after rom_addr is sampled
//   write_ready     : codec FIFO can take a sample
//   write           : a sample is being offered (only while PRESENT)
//   writedata_left  : left-channel sample
//   writedata_right : right-channel sample
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse when a one-shot playback finishes
//   o_dbg_state     : current FSM state (0 IDLE, 1 FETCH, 2 WAIT, 3 PRESENT)
//
// Handshake: a sample transfers on every rising clock edge where
// write && write_ready. Once write is raised, the data words stay
// stable until that transfer happens. write_ready may toggle freely and
// has no effect while write is low.
// ---------------------------------------------------------------------------
module rom_sample_streamer #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 48000,
    parameter int STEP_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [STEP_W-1:0] step,
    input  logic [3:0]        atten_l,
    input  logic [3:0]        atten_r,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              write_ready,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              busy,
    output logic              done,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_WAIT    = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    localparam int              CNT_W      = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CNT_W-1:0] L_CNT_LOAD = CNT_W'(ROM_LAT - 1);
    // DEPTH can be 2^ADDR_W, so all address arithmetic uses ADDR_W+1 bits.
    localparam logic [ADDR_W:0]  L_DEPTH    = (ADDR_W + 1)'(DEPTH);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_W-1:0]         r_addr;
    logic [CNT_W-1:0]          r_wait_cnt;
    logic [DATA_W-1:0]         r_left;
    logic [DATA_W-1:0]         r_right;
    logic                      r_done;

    logic [ADDR_W:0]           w_step_eff;
    logic [ADDR_W:0]           w_nxt;
    logic [ADDR_W:0]           w_wrap;
    logic                      w_abort;
    logic signed [DATA_W-1:0]  w_rom_s;
    logic signed [DATA_W-1:0]  w_shift_l;
    logic signed [DATA_W-1:0]  w_shift_r;

    // A step of 0 would stall on one address forever, so it is treated as 1.
    assign w_step_eff = (step == '0) ? (ADDR_W + 1)'(1) : (ADDR_W + 1)'(step);
    assign w_nxt      = {1'b0, r_addr} + w_step_eff;
    assign w_wrap     = w_nxt - L_DEPTH;
    assign w_abort    = stop && (r_state != S_IDLE);

    // The sample is signed, so the attenuation shifts must keep the sign.
    assign w_rom_s    = $signed(rom_q);
    assign w_shift_l  = w_rom_s >>> atten_l;
    assign w_shift_r  = w_rom_s >>> atten_r;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (write_ready) begin
                    if ((w_nxt < L_DEPTH) || loop_en) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // An abort overrides any transition. A sample accepted in the same
        // cycle still counts as delivered.
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers: address, latency counter, sample words, done
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_wait_cnt <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_addr <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            r_addr <= '0;
                        end
                    end
                    S_FETCH: begin
                        r_wait_cnt <= L_CNT_LOAD;
                    end
                    S_WAIT: begin
                        if (r_wait_cnt != '0) begin
                            r_wait_cnt <= r_wait_cnt - 1'b1;
                        end else begin
                            r_left  <= w_shift_l;
                            r_right <= w_shift_r;
                        end
                    end
                    S_PRESENT: begin
                        if (write_ready) begin
                            if (w_nxt < L_DEPTH) begin
                                r_addr <= w_nxt[ADDR_W-1:0];
                            end else if (loop_en) begin
                                // A step of DEPTH or more is out of range. In
                                // that case restart at 0 instead of going out
                                // of bounds.
                                r_addr <= (w_wrap < L_DEPTH) ? w_wrap[ADDR_W-1:0] : '0;
                            end else begin
                                r_addr <= '0;
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_addr <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        rom_addr        = r_addr;
        write           = (r_state == S_PRESENT);
        busy            = (r_state != S_IDLE);
        done            = r_done;
        writedata_left  = r_left;
        writedata_right = r_right;
        o_dbg_state     = r_state;
    end

endmodule

// File: tb/tb_rom_sample_streamer.sv
// Bench for rom_sample_streamer: two instances (ROM latency 1 and 2) share
// the stimulus. A mux selects which instance the checks observe.
module tb_rom_sample_streamer;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int STEP_W = 4;

    // clock / reset block
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset       = 1'b1;
    logic              start       = 1'b0;
    logic              stop        = 1'b0;
    logic              loop_en     = 1'b0;
    logic [STEP_W-1:0] step        = 4'd1;
    logic [3:0]        atten_l     = 4'd0;
    logic [3:0]        atten_r     = 4'd0;
    logic              write_ready = 1'b1;
    logic              sel2        = 1'b0;

    logic [DATA_W-1:0] rom_mem [DEPTH];

    logic [ADDR_W-1:0] rom_addr1, rom_addr2;
    logic [DATA_W-1:0] rom_q1, rom_q2, rom_s2;
    logic              write1, write2, busy1, busy2, done1, done2;
    logic [DATA_W-1:0] left1, left2, right1, right2;
    logic [1:0]        state1, state2;

    rom_sample_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                          .STEP_W(STEP_W), .ROM_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .loop_en(loop_en), .step(step), .atten_l(atten_l), .atten_r(atten_r),
        .rom_addr(rom_addr1), .rom_q(rom_q1), .write_ready(write_ready),
        .write(write1), .writedata_left(left1), .writedata_right(right1),
        .busy(busy1), .done(done1), .o_dbg_state(state1)
    );

    rom_sample_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                          .STEP_W(STEP_W), .ROM_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .loop_en(loop_en), .step(step), .atten_l(atten_l), .atten_r(atten_r),
        .rom_addr(rom_addr2), .rom_q(rom_q2), .write_ready(write_ready),
        .write(write2), .writedata_left(left2), .writedata_right(right2),
        .busy(busy2), .done(done2), .o_dbg_state(state2)
    );

    // ROM models: one registered stage, and two stages.
    always @(posedge clock) rom_q1 <= rom_mem[rom_addr1[2:0]];
    always @(posedge clock) begin
        rom_s2 <= rom_mem[rom_addr2[2:0]];
        rom_q2 <= rom_s2;
    end

    logic [ADDR_W-1:0] rom_addr_m;
    logic              write_m, busy_m, done_m;
    logic [DATA_W-1:0] left_m, right_m;
    logic [1:0]        state_m;
    assign rom_addr_m = sel2 ? rom_addr2 : rom_addr1;
    assign write_m    = sel2 ? write2    : write1;
    assign busy_m     = sel2 ? busy2     : busy1;
    assign done_m     = sel2 ? done2     : done1;
    assign left_m     = sel2 ? left2     : left1;
    assign right_m    = sel2 ? right2    : right1;
    assign state_m    = sel2 ? state2    : state1;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic tick();
        @(negedge clock);
        if (done_m) done_cnt++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: attenuation is floor division by 2^k on the signed value.
    function automatic logic [DATA_W-1:0] m_atten(input logic [DATA_W-1:0] x, input int k);
        longint v, p;
        v = longint'($signed(x));
        p = longint'(1) << k;
        if (v < 0) v = -((-v + p - 1) / p);
        else       v = v / p;
        return v[DATA_W-1:0];
    endfunction

    // Reference model: address of the next sample, fin=1 when a one-shot ends.
    function automatic int m_next(input int a, input int st, input bit lp, output bit fin);
        int n;
        n   = a + ((st == 0) ? 1 : st);
        fin = 1'b0;
        if (n < DEPTH) return n;
        if (lp) return (n - DEPTH < DEPTH) ? n - DEPTH : 0;
        fin = 1'b1;
        return 0;
    endfunction

    // driver: waits for the offer, checks it, then completes the handshake
    task automatic take(input string tag, input int exp_a, input bit rnd_ready, output int waited);
        int n;
        logic [DATA_W-1:0] hl, hr;
        n = 0;
        while (!write_m && n < 40) begin tick(); n++; end
        waited = n;
        check({tag, " offer"}, 64'(write_m), 64'd1);
        if (!write_m) return;
        check({tag, " addr"},  64'(rom_addr_m), 64'(exp_a));
        check({tag, " left"},  64'(left_m),  64'(m_atten(rom_mem[exp_a], int'(atten_l))));
        check({tag, " right"}, 64'(right_m), 64'(m_atten(rom_mem[exp_a], int'(atten_r))));
        hl = left_m;
        hr = right_m;
        write_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!write_ready && n < 80) begin
            tick(); n++;
            check({tag, " hold write"}, 64'(write_m), 64'd1);
            check({tag, " hold data"}, {16'd0, left_m, right_m}, {16'd0, hl, hr});
            write_ready = 1'($urandom_range(0, 1));
        end
        write_ready = 1'b1;
        tick();
    endtask

    // driver: a whole one-shot playback against the model's address list
    task automatic run_oneshot(input string tag, input bit rnd_ready);
        int a, w, d0;
        bit fin;
        exp_q.delete();
        a = 0;
        fin = 1'b0;
        while (!fin) begin
            exp_q.push_back(ADDR_W'(a));
            a = m_next(a, int'(step), 1'b0, fin);
        end
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        while (exp_q.size() > 0) begin
            a = int'(exp_q.pop_front());
            take(tag, a, rnd_ready, w);
        end
        check({tag, " done"}, 64'(done_m), 64'd1);
        check({tag, " busy end"}, 64'(busy_m), 64'd0);
        check({tag, " addr end"}, 64'(rom_addr_m), 64'd0);
        tick();
        check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int lat, w, a, d0;
        bit fin;
        int tbl [9] = '{0, 3, 6, 1, 4, 7, 2, 5, 0};

        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'(i * 256);

        // reset state
        repeat (3) tick();
        check("rst write", 64'(write1), 64'd0);
        check("rst busy", 64'(busy1), 64'd0);
        check("rst done", 64'(done1), 64'd0);
        check("rst addr", 64'(rom_addr1), 64'd0);
        check("rst data", {16'd0, left1, right1}, 64'd0);
        check("rst busy2", 64'(busy2), 64'd0);
        reset = 1'b0;
        tick();

        // basic one-shot, latency and sample period
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        lat = 1;
        while (!write_m && lat < 10) begin tick(); lat++; end
        check("latency lat1", 64'(lat), 64'd3);
        for (int i = 0; i < DEPTH; i++) begin
            take("basic", i, 1'b0, w);
            if (i > 0) check("period lat1", 64'(w), 64'd2);
        end
        check("basic done", 64'(done_m), 64'd1);
        check("basic busy", 64'(busy_m), 64'd0);
        check("basic addr", 64'(rom_addr_m), 64'd0);
        check("basic left hold", 64'(left_m), 64'd1792);
        tick();
        check("basic done once", 64'(done_cnt - d0), 64'd1);

        // loop with step wrap
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'($urandom);
        loop_en = 1'b1; step = 4'd3;
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            take("loop3", tbl[i], 1'b0, w);
            check("loop3 busy", 64'(busy_m), 64'd1);
        end
        a = 0;
        for (int i = 0; i < 10; i++) begin
            a = m_next(a, 3, 1'b1, fin);
            take("loop3 rnd", a, 1'b1, w);
        end
        check("loop3 no done", 64'(done_cnt - d0), 64'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        check("loop stop busy", 64'(busy_m), 64'd0);
        check("loop stop addr", 64'(rom_addr_m), 64'd0);

        // backpressure at addr 2, then stop in WAIT at addr 5
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'(i * 256);
        step = 4'd1;
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        take("bp", 0, 1'b0, w);
        take("bp", 1, 1'b0, w);
        write_ready = 1'b0;
        lat = 0;
        while (!write_m && lat < 10) begin tick(); lat++; end
        for (int i = 0; i < 10; i++) begin
            check("bp write", 64'(write_m), 64'd1);
            check("bp data", 64'(left_m), 64'd512);
            check("bp addr", 64'(rom_addr_m), 64'd2);
            tick();
        end
        take("bp", 2, 1'b0, w);
        take("bp", 3, 1'b0, w);
        check("bp no skip", 64'(w), 64'd2);
        take("bp", 4, 1'b0, w);
        tick();
        check("stop at wait", 64'(state_m), 64'd2);
        check("stop at addr", 64'(rom_addr_m), 64'd5);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop busy", 64'(busy_m), 64'd0);
        check("stop write", 64'(write_m), 64'd0);
        check("stop done", 64'(done_m), 64'd0);
        check("stop addr", 64'(rom_addr_m), 64'd0);
        check("stop hold", 64'(left_m), 64'd1024);
        start = 1'b1; tick(); start = 1'b0;
        take("replay", 0, 1'b0, w);
        take("replay", 1, 1'b0, w);
        stop = 1'b1; tick(); stop = 1'b0;
        check("replay no done", 64'(done_cnt - d0), 64'd0);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("start+stop idle", 64'(busy_m), 64'd0);
        end
        start = 1'b0; stop = 1'b0;

        // attenuation and sign, start held high throughout
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 24'hF00000;
        atten_l = 4'd4; atten_r = 4'd0; loop_en = 1'b0;
        start = 1'b1;
        lat = 0;
        while (!write_m && lat < 10) begin tick(); lat++; end
        check("atten left", 64'(left_m), 64'hFF0000);
        check("atten right", 64'(right_m), 64'hF00000);
        for (int i = 0; i < DEPTH; i++) take("atten", i, 1'b0, w);
        check("atten done", 64'(done_m), 64'd1);
        check("atten idle", 64'(busy_m), 64'd0);
        tick();
        check("restart held", 64'(busy_m), 64'd1);
        start = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0;

        // randomized one-shots; the first uses step 0
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'($urandom);
            step    = (it == 0) ? 4'd0 : 4'($urandom_range(0, 7));
            atten_l = 4'($urandom_range(0, 15));
            atten_r = 4'($urandom_range(0, 15));
            run_oneshot("rand", 1'b1);
        end

        // reset while PRESENT
        rom_mem[0] = 24'h123456;
        atten_l = 4'd0; atten_r = 4'd0; step = 4'd1;
        start = 1'b1; tick(); start = 1'b0;
        lat = 0;
        while (!write_m && lat < 10) begin tick(); lat++; end
        check("pre-reset offer", 64'(write_m), 64'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid rst write", 64'(write_m), 64'd0);
        check("mid rst busy", 64'(busy_m), 64'd0);
        check("mid rst done", 64'(done_m), 64'd0);
        check("mid rst addr", 64'(rom_addr_m), 64'd0);
        check("mid rst data", {16'd0, left_m, right_m}, 64'd0);

        // ROM latency 2 instance
        sel2 = 1'b1;
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DATA_W'($urandom);
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        lat = 1;
        while (!write_m && lat < 10) begin tick(); lat++; end
        check("latency lat2", 64'(lat), 64'd4);
        for (int i = 0; i < DEPTH; i++) begin
            take("lat2", i, 1'b0, w);
            if (i > 0) check("period lat2", 64'(w), 64'd3);
        end
        check("lat2 done", 64'(done_m), 64'd1);
        tick();
        check("lat2 done once", 64'(done_cnt - d0), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
